div_result_bcd: RTL and testbench



---
 rtl/div_fmt_pkg.sv | 31 +++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/div_result_bcd.sv | 187 ++++++++++++++++++
 tb/tb_div_result_bcd.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/div_fmt_pkg.sv
// div_fmt_pkg: shared definitions for the divider result BCD formatter.
//   - state_e      : formatter FSM states
//   - DEF_WIDTH    : default binary width (divider quotient width)
//   - DEF_DIGITS   : default BCD digit count
//   - DEF_CNT_W    : bit-counter width for the default binary width
//   - nib_add3()   : double-dabble nibble correction (>=5 gets +3)
package div_fmt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DIGITS = 5;
  localparam int DEF_CNT_W  = $clog2(DEF_WIDTH);

  // A nibble of 5..9 would become >=10 after the next doubling, so pre-add 3
  // to make the carry land in the next digit.
  function automatic logic [3:0] nib_add3(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: combinational single-digit double-dabble corrector.
// Ports:
//   i_nib  in  4  BCD digit before the shift
//   o_nib  out 4  digit with +3 applied when it is 5 or more
module bcd_digit_adj
  import div_fmt_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = nib_add3(i_nib);

endmodule

// File: rtl/div_result_bcd.sv
// div_result_bcd: sequential binary-to-packed-BCD formatter for the divider
// quotient. Accepts one word per valid/ready handshake, optionally as two's
// complement, converts its magnitude one bit per cycle by shift-and-add-3 and
// holds digits, sign and significant-digit count until the consumer takes them.
// Ports:
//   clock        in   1         rising-edge clock
//   rst_n        in   1         asynchronous active-low reset
//   in_valid     in   1         quotient available
//   in_ready     out  1         high only while idle
//   in_value     in   WIDTH     quotient
//   in_signed    in   1         interpret in_value as two's complement
//   out_valid    out  1         result held stable
//   out_ready    in   1         consumer takes result
//   out_bcd      out  4*DIGITS  packed BCD, digit 0 in [3:0]
//   out_neg      out  1         input was negative (signed mode)
//   out_ndigits  out  3         significant digits, 1..DIGITS
module div_result_bcd
  import div_fmt_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_value,
  input  logic                in_signed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_neg,
  output logic [2:0]          out_ndigits
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = 4 * DIGITS;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_bcd;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic [BW-1:0]    r_out_bcd;
  logic             r_out_neg;
  logic [2:0]       r_out_ndigits;

  logic             w_accept;
  logic             w_last;
  logic             w_is_neg;
  logic [WIDTH-1:0] w_mag;
  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_bcd_nxt;
  logic [2:0]       w_ndig;
  logic             w_unused_msb;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_state == ST_SHIFT) && (r_cnt == CW'(WIDTH - 1));
  assign w_is_neg = in_signed & in_value[WIDTH-1];
  // Subtracting from zero maps the most negative value onto its unsigned magnitude.
  assign w_mag    = w_is_neg ? ({WIDTH{1'b0}} - in_value) : in_value;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_nib (r_bcd[4*g +: 4]),
      .o_nib (w_adj[4*g +: 4])
    );
  end

  // {bcd, bin} shifted left by one after correction. The top digit never
  // reaches 8 because 10^DIGITS exceeds the input range, so its MSB is dropped.
  assign w_bcd_nxt    = {w_adj[BW-2:0], r_bin[WIDTH-1]};
  assign w_unused_msb = w_adj[BW-1];

  // Significant-digit count of the final BCD word: highest nonzero digit + 1.
  always_comb begin
    w_ndig = 3'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_bcd_nxt[4*i +: 4] != 4'd0) begin
        w_ndig = 3'(i + 1);
      end else begin
        w_ndig = w_ndig;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM handshake outputs, decoded from the registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE:  in_ready  = 1'b1;
      ST_SHIFT: in_ready  = 1'b0;
      ST_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Conversion datapath: capture magnitude on accept, shift-and-add-3 per cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= {WIDTH{1'b0}};
      r_bcd <= {BW{1'b0}};
      r_cnt <= {CW{1'b0}};
      r_neg <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_bin <= w_mag;
            r_bcd <= {BW{1'b0}};
            r_cnt <= {CW{1'b0}};
            r_neg <= w_is_neg;
          end
        end
        ST_SHIFT: begin
          r_bcd <= w_bcd_nxt;
          r_bin <= {r_bin[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Result registers: loaded only on the DONE-entry edge, held otherwise.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_out_bcd     <= {BW{1'b0}};
      r_out_neg     <= 1'b0;
      r_out_ndigits <= 3'd1;
    end else if (w_last) begin
      r_out_bcd     <= w_bcd_nxt;
      r_out_neg     <= r_neg;
      r_out_ndigits <= w_ndig;
    end
  end

  assign out_bcd     = r_out_bcd;
  assign out_neg     = r_out_neg;
  assign out_ndigits = r_out_ndigits;

endmodule

// File: tb/tb_div_result_bcd.sv
// tb_div_result_bcd: directed self-checking bench for div_result_bcd.
module tb_div_result_bcd;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_value = 16'd0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] out_bcd;
  logic        out_neg;
  logic [2:0]  out_ndigits;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;

  div_result_bcd #(.WIDTH(16), .DIGITS(5)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_value    (in_value),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bcd     (out_bcd),
    .out_neg     (out_neg),
    .out_ndigits (out_ndigits)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by repeated division.
  function automatic logic [19:0] ref_bcd(input logic [15:0] v, input logic s);
    int m;
    logic [19:0] r;
    m = (s && v[15]) ? (65536 - int'(v)) : int'(v);
    r = 20'd0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic int ref_nd(input logic [15:0] v, input logic s);
    int m;
    int nd;
    m = (s && v[15]) ? (65536 - int'(v)) : int'(v);
    nd = 1;
    while (m >= 10) begin
      nd++;
      m = m / 10;
    end
    return nd;
  endfunction

  // One full conversion with latency, result and handshake checks.
  task automatic run_conv(input string tag, input logic [15:0] v, input logic s,
                          input logic [19:0] eb, input logic en, input logic [2:0] ed);
    int lat;
    @(negedge clock);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clock);
    in_valid = 1'b1; in_value = v; in_signed = s;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 16);
    chk({tag, "_bcd"}, out_bcd, eb);
    chk({tag, "_neg"}, out_neg, en);
    chk({tag, "_nd"}, out_ndigits, ed);
    @(negedge clock); out_ready = 1'b1;
    @(posedge clock); #1; out_ready = 1'b0;
    chk({tag, "_vld_fall"}, out_valid, 0);
    chk({tag, "_rdy_rise"}, in_ready, 1);
  endtask

  logic [15:0] vals [10];
  logic        sgns [10];
  int          acc, prev_acc, w;

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bcd", out_bcd, 0);
    chk("rst_out_neg", out_neg, 0);
    chk("rst_out_nd", out_ndigits, 1);
    @(negedge clock); rst_n = 1'b1;

    run_conv("u488",   16'd488,   1'b0, 20'h00488, 1'b0, 3'd3);
    run_conv("u0",     16'd0,     1'b0, 20'h00000, 1'b0, 3'd1);
    run_conv("u65535", 16'hFFFF,  1'b0, 20'h65535, 1'b0, 3'd5);
    run_conv("sFFFF",  16'hFFFF,  1'b1, 20'h00001, 1'b1, 3'd1);
    run_conv("s8000",  16'h8000,  1'b1, 20'h32768, 1'b1, 3'd5);
    run_conv("u8000",  16'h8000,  1'b0, 20'h32768, 1'b0, 3'd5);
    run_conv("s0",     16'h0000,  1'b1, 20'h00000, 1'b0, 3'd1);
    run_conv("s7FFF",  16'h7FFF,  1'b1, 20'h32767, 1'b0, 3'd5);
    run_conv("s_m10",  16'hFFF6,  1'b1, 20'h00010, 1'b1, 3'd2);

    // Backpressure with ignored in_valid pulses during SHIFT and DONE.
    @(negedge clock);
    in_valid = 1'b1; in_value = 16'd1234; in_signed = 1'b0;
    @(posedge clock); #1; in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1; in_valid = 1'b1; in_value = 16'd999;
    @(posedge clock); #1; in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin @(posedge clock); #1; w++; end
    chk("bp_vld", out_valid, 1);
    in_valid = 1'b1; in_value = 16'd777;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_hold_bcd", out_bcd, 20'h01234);
      chk("bp_hold_vld", out_valid, 1);
    end
    chk("bp_hold_nd", out_ndigits, 4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1; out_ready = 1'b0;
    chk("bp_rdy_after", in_ready, 1);
    chk("bp_vld_after", out_valid, 0);
    @(negedge clock);
    chk("bp_idle_hold", out_bcd, 20'h01234);

    // Reset during the 7th SHIFT cycle of 12345.
    @(negedge clock);
    in_valid = 1'b1; in_value = 16'd12345; in_signed = 1'b0;
    @(posedge clock); #1; in_valid = 1'b0;
    repeat (6) @(posedge clock);
    #3; rst_n = 1'b0; #1;
    chk("mrst_vld", out_valid, 0);
    chk("mrst_bcd", out_bcd, 0);
    chk("mrst_rdy", in_ready, 1);
    chk("mrst_nd", out_ndigits, 1);
    @(negedge clock); rst_n = 1'b1;
    run_conv("u12345", 16'd12345, 1'b0, 20'h12345, 1'b0, 3'd5);

    // Back-to-back with in_valid held and out_ready high.
    for (int k = 0; k < 10; k++) begin
      vals[k] = 16'($urandom);
      sgns[k] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    prev_acc = 0;
    for (int k = 0; k < 10; k++) begin
      in_value = vals[k]; in_signed = sgns[k]; in_valid = 1'b1;
      @(negedge clock);
      w = 0;
      while (!in_ready && w < 40) begin @(negedge clock); w++; end
      acc = cyc;
      @(posedge clock); #1;
      if (k > 0) chk("b2b_spacing", acc - prev_acc, 18);
      prev_acc = acc;
      @(negedge clock);
      w = 0;
      while (!out_valid && w < 40) begin @(negedge clock); w++; end
      chk("b2b_bcd", out_bcd, ref_bcd(vals[k], sgns[k]));
      chk("b2b_neg", out_neg, sgns[k] & vals[k][15] & (vals[k] != 16'd0));
      chk("b2b_nd", out_ndigits, ref_nd(vals[k], sgns[k]));
    end
    in_valid = 1'b0;
    @(posedge clock); #1; out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
